// File: rtl/line_tracker_pkg.sv
// Shared motion-command encodings for the line tracker and downstream motor-control blocks.
package line_tracker_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned TIMER_W = 24;

  typedef enum logic [STATE_W-1:0] {
    StStop        = 3'd0,
    StForward     = 3'd1,
    StBack        = 3'd2,
    StLeft        = 3'd3,
    StRight       = 3'd4,
    StStrongLeft  = 3'd5,
    StStrongRight = 3'd6
  } state_e;

  // Leftmost channel (index n-1) gets the most negative weight.
  function automatic int ch_weight(input int n, input int i);
    return (n - 1) / 2 - i;
  endfunction

endpackage

// File: rtl/line_tracker_fsm_if.sv
// Tracker command/status bundle: controller-side (master) and tracker-side (slave) views.
interface line_tracker_fsm_if #(
  parameter int unsigned N_SENSORS = 3
);
  import line_tracker_pkg::*;

  logic                 enable;
  logic [N_SENSORS-1:0] sensor;
  state_e               state;
  logic                 line_lost;
  logic [N_SENSORS-1:0] filt;

  modport master (
    output enable,
    output sensor,
    input  state,
    input  line_lost,
    input  filt
  );

  modport slave (
    input  enable,
    input  sensor,
    output state,
    output line_lost,
    output filt
  );

endinterface

// File: rtl/line_tracker_fsm_sensor_debounce.sv
// One reflectance channel: 2-flop synchroniser followed by a FILTER_LEN-sample debounce.
module sensor_debounce #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_filt
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]      r_sync;
  logic [CntW-1:0] r_cnt;
  logic            r_filt;
  logic [CntW-1:0] w_cnt_d;
  logic            w_filt_d;

  // Any sample that agrees with the accepted value restarts the run.
  always_comb begin
    w_cnt_d  = '0;
    w_filt_d = r_filt;
    if (r_sync[1] != r_filt) begin
      if (r_cnt == CntW'(FILTER_LEN - 1)) begin
        w_filt_d = r_sync[1];
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_cnt  <= w_cnt_d;
      r_filt <= w_filt_d;
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/line_tracker_fsm.sv
// Line tracker: debounced sensor array -> weighted position -> registered motion command,
// with a bounded search when the line disappears.
module line_tracker_fsm
  import line_tracker_pkg::*;
#(
  parameter int unsigned N_SENSORS     = 3,
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned LOST_TIMEOUT  = 1_000_000,
  parameter int unsigned STRONG_THRESH = 2
) (
  input logic              clk,
  input logic              reset,
  line_tracker_fsm_if.slave bus
);

  localparam int unsigned SumW   = $clog2(N_SENSORS * N_SENSORS) + 1;
  localparam int unsigned Centre = (N_SENSORS - 1) / 2;
  localparam int          Thr    = int'(STRONG_THRESH);
  localparam logic [TIMER_W-1:0] TimeoutV = TIMER_W'(LOST_TIMEOUT);

  logic [1:0]                r_rst_sync;
  logic                      w_rst_n;
  logic [N_SENSORS-1:0]      w_filt;
  logic signed [SumW-1:0]    w_sum;
  int                        w_s;
  logic                      w_centre;
  state_e                    r_state, w_state_d, w_track;
  logic                      r_lost, w_lost_d;
  logic [TIMER_W-1:0]        r_timer, w_timer_d;

  // Assert immediately, release two edges after the pin goes high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_ch
    sensor_debounce #(
      .FILTER_LEN(FILTER_LEN)
    ) u_deb (
      .clk   (clk),
      .rst_n (w_rst_n),
      .i_raw (bus.sensor[g]),
      .o_filt(w_filt[g])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (w_filt[i]) w_sum = w_sum + SumW'(ch_weight(int'(N_SENSORS), i));
    end
  end
  assign w_s      = int'(w_sum);
  assign w_centre = w_filt[Centre];

  always_comb begin
    w_track = StBack;
    if (w_centre) begin
      if (w_s == 0)         w_track = StForward;
      else if (w_s < -Thr)  w_track = StStrongLeft;
      else if (w_s < 0)     w_track = StLeft;
      else if (w_s > Thr)   w_track = StStrongRight;
      else                  w_track = StRight;
    end else begin
      if (w_s < 0)          w_track = StStrongLeft;
      else if (w_s > 0)     w_track = StStrongRight;
      else                  w_track = StBack;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_lost_d  = r_lost;
    w_timer_d = r_timer;
    if (!bus.enable) begin
      w_state_d = StStop;
      w_lost_d  = 1'b0;
      w_timer_d = '0;
    end else if (w_filt != '0) begin
      w_state_d = w_track;
      w_lost_d  = 1'b0;
      w_timer_d = '0;
    end else if (r_timer == TimeoutV) begin
      w_state_d = StStop;
      w_lost_d  = 1'b1;
    end else begin
      w_timer_d = r_timer + 1'b1;
      // Search in the direction the line was last seen.
      case (r_state)
        StLeft, StStrongLeft:   w_state_d = StStrongLeft;
        StRight, StStrongRight: w_state_d = StStrongRight;
        StStop:                 w_state_d = r_lost ? StStop : StBack;
        default:                w_state_d = StBack;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= StStop;
      r_lost  <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_d;
      r_lost  <= w_lost_d;
      r_timer <= w_timer_d;
    end
  end

  assign bus.state     = r_state;
  assign bus.line_lost = r_lost;
  assign bus.filt      = w_filt;

endmodule

// File: tb/tb_line_tracker_fsm.sv
// Directed bench for line_tracker_fsm: a 3-sensor and a 5-sensor instance on a shared clock/reset.
module tb_line_tracker_fsm;
  import line_tracker_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  line_tracker_fsm_if #(.N_SENSORS(3)) bus3 ();
  line_tracker_fsm_if #(.N_SENSORS(5)) bus5 ();

  line_tracker_fsm #(
    .N_SENSORS    (3),
    .FILTER_LEN   (4),
    .LOST_TIMEOUT (100),
    .STRONG_THRESH(2)
  ) dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3)
  );

  line_tracker_fsm #(
    .N_SENSORS    (5),
    .FILTER_LEN   (2),
    .LOST_TIMEOUT (100),
    .STRONG_THRESH(2)
  ) dut5 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus5)
  );

  logic [2:0] pat3 [8] = '{3'b001, 3'b011, 3'b010, 3'b111, 3'b110, 3'b000, 3'b100, 3'b101};
  state_e     exp3 [8] = '{StStrongRight, StRight, StForward, StForward,
                           StLeft, StStrongLeft, StStrongLeft, StBack};
  logic [4:0] pat5 [5] = '{5'b01100, 5'b11100, 5'b00110, 5'b10001, 5'b00111};
  state_e     exp5 [5] = '{StLeft, StStrongLeft, StRight, StBack, StStrongRight};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    bus3.enable = 1'b0;
    bus3.sensor = '0;
    bus5.enable = 1'b0;
    bus5.sensor = '0;

    tick(3);
    chk("rst_state3", bus3.state, StStop);
    chk("rst_lost3", bus3.line_lost, 1'b0);
    chk("rst_filt3", bus3.filt, 3'b000);
    chk("rst_state5", bus5.state, StStop);

    @(negedge clk);
    reset       = 1'b1;
    bus3.enable = 1'b1;
    bus5.enable = 1'b1;
    tick(2);
    chk("rst_release_hold", bus3.state, StStop);
    tick(1);
    chk("first_update_back", bus3.state, StBack);

    // Latency: filt after 6 edges, state after 7.
    bus3.sensor = 3'b010;
    tick(5);
    chk("lat_filt_e5", bus3.filt, 3'b000);
    tick(1);
    chk("lat_filt_e6", bus3.filt, 3'b010);
    chk("lat_state_e6", bus3.state, StBack);
    tick(1);
    chk("lat_state_e7", bus3.state, StForward);

    bus3.sensor = 3'b000;
    tick(1);
    bus3.sensor = 3'b010;
    tick(10);
    chk("glitch_state", bus3.state, StForward);
    chk("glitch_filt", bus3.filt, 3'b010);

    for (int k = 0; k < 8; k++) begin
      bus3.sensor = pat3[k];
      tick(10);
      chk($sformatf("pat3_%b", pat3[k]), bus3.state, exp3[k]);
      chk($sformatf("pat3_lost_%b", pat3[k]), bus3.line_lost, 1'b0);
    end

    for (int k = 0; k < 5; k++) begin
      bus5.sensor = pat5[k];
      tick(10);
      chk($sformatf("pat5_%b", pat5[k]), bus5.state, exp5[k]);
      chk($sformatf("pat5_filt_%b", pat5[k]), bus5.filt, pat5[k]);
    end

    // Search timeout from RIGHT.
    bus3.sensor = 3'b011;
    tick(10);
    chk("to_right", bus3.state, StRight);
    bus3.sensor = 3'b000;
    tick(6);
    chk("to_filt0", bus3.filt, 3'b000);
    chk("to_still_right", bus3.state, StRight);
    tick(1);
    chk("to_search_first", bus3.state, StStrongRight);
    tick(99);
    chk("to_search_last", bus3.state, StStrongRight);
    chk("to_search_last_lost", bus3.line_lost, 1'b0);
    tick(1);
    chk("to_stop", bus3.state, StStop);
    chk("to_lost", bus3.line_lost, 1'b1);
    tick(5);
    chk("to_parked", bus3.state, StStop);
    chk("to_parked_lost", bus3.line_lost, 1'b1);
    bus3.sensor = 3'b010;
    tick(6);
    chk("to_reacq_filt", bus3.filt, 3'b010);
    chk("to_reacq_hold", bus3.line_lost, 1'b1);
    tick(1);
    chk("to_reacq_state", bus3.state, StForward);
    chk("to_reacq_lost", bus3.line_lost, 1'b0);

    // enable=0 forces STOP while debounce keeps running.
    bus3.enable = 1'b0;
    tick(1);
    chk("dis_stop", bus3.state, StStop);
    chk("dis_lost", bus3.line_lost, 1'b0);
    bus3.sensor = 3'b110;
    tick(6);
    chk("dis_filt_runs", bus3.filt, 3'b110);
    chk("dis_still_stop", bus3.state, StStop);
    bus3.enable = 1'b1;
    tick(1);
    chk("en_left", bus3.state, StLeft);

    // Disabling mid-search restarts the full timeout.
    bus3.sensor = 3'b000;
    tick(6);
    chk("tclr_left", bus3.state, StLeft);
    tick(50);
    chk("tclr_search", bus3.state, StStrongLeft);
    bus3.enable = 1'b0;
    tick(2);
    chk("tclr_stop", bus3.state, StStop);
    bus3.enable = 1'b1;
    tick(100);
    chk("tclr_back", bus3.state, StBack);
    chk("tclr_not_lost", bus3.line_lost, 1'b0);
    tick(1);
    chk("tclr_timeout", bus3.state, StStop);
    chk("tclr_timeout_lost", bus3.line_lost, 1'b1);

    // Async reset during a directional search.
    bus3.sensor = 3'b011;
    tick(10);
    bus3.sensor = 3'b000;
    tick(8);
    chk("ar_searching", bus3.state, StStrongRight);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_state", bus3.state, StStop);
    chk("ar_lost", bus3.line_lost, 1'b0);
    chk("ar_filt5", bus5.filt, 5'b00000);
    chk("ar_state5", bus5.state, StStop);
    reset = 1'b1;
    tick(2);
    chk("ar_release_hold", bus3.state, StStop);
    tick(1);
    chk("ar_no_memory", bus3.state, StBack);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_tracker_fsm.md
LINE_TRACKER_FSM -- requirements
Module: line_tracker_fsm

Interface
REQ-001 Parameter N_SENSORS, default 3: number of reflectance channels; odd, 3..9.
REQ-002 Parameter FILTER_LEN, default 4: consecutive equal samples needed to accept a channel change; range 1..255.
REQ-003 Parameter LOST_TIMEOUT, default 1_000_000: clock cycles spent searching before giving up; range 1..2^24-1.
REQ-004 Parameter STRONG_THRESH, default 2: weight-sum magnitude above which a turn with centre sensor lit becomes STRONG.
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  1 = track, 0 = hold STOP.
REQ-008 sensor  input  N_SENSORS  raw asynchronous line-detect bits; bit N_SENSORS-1 leftmost, bit 0 rightmost, 1 = line seen.
REQ-009 state  output  3  registered motion command: STOP=0, FORWARD=1, BACK=2, LEFT=3, RIGHT=4, STRONG_LEFT=5, STRONG_RIGHT=6.
REQ-010 line_lost  output  1  registered; 1 while search timed out and block is parked in STOP.
REQ-011 filt  output  N_SENSORS  registered debounced sensor vector.

Function
REQ-012 Each sensor bit SHALL pass through a 2-flop synchroniser, then a debounce counter; filt[i] SHALL update only after FILTER_LEN consecutive synchronised samples differ from current filt[i]; any matching sample clears the count.
REQ-013 Latency: a sensor change held stable SHALL reach filt after 2+FILTER_LEN rising edges and state one edge later.
REQ-014 Channel i weight SHALL be w(i) = (N_SENSORS-1)/2 - i (left positive index → negative weight convention: leftmost = -(N-1)/2); s = signed sum of weights of lit channels, width ceil(log2(N^2))+1 bits, no overflow.
REQ-015 c = centre channel lit. Next state with filt non-zero: c and s==0 → FORWARD; c and -STRONG_THRESH<=s<0 → LEFT; c and 0<s<=STRONG_THRESH → RIGHT; c and s<-STRONG_THRESH → STRONG_LEFT; c and s>STRONG_THRESH → STRONG_RIGHT; !c and s<0 → STRONG_LEFT; !c and s>0 → STRONG_RIGHT; !c and s==0 → BACK.
REQ-016 filt all-zero (lost) with timer below LOST_TIMEOUT: current LEFT or STRONG_LEFT → STRONG_LEFT; RIGHT or STRONG_RIGHT → STRONG_RIGHT; BACK/FORWARD → BACK; STOP stays STOP only if line_lost=1, else BACK.
REQ-017 Lost timer SHALL increment each cycle filt is all-zero and enable=1, saturate at LOST_TIMEOUT, and clear on the first cycle filt is non-zero.
REQ-018 When timer reaches LOST_TIMEOUT, next edge SHALL set state=STOP and line_lost=1; both held until filt becomes non-zero, then REQ-015 applies the same edge and line_lost clears.
REQ-019 enable=0 SHALL force state=STOP, line_lost=0, timer=0 on the next edge; synchroniser and debounce continue running.
REQ-020 With N_SENSORS=3, STRONG_THRESH>=1, REQ-015/016 SHALL reproduce the legacy 3-sensor tracker truth table (001→STRONG_RIGHT, 011→RIGHT, 010/111→FORWARD, 110→LEFT, 100→STRONG_LEFT, 101→BACK).

Reset
REQ-021 reset low SHALL immediately set state=STOP, line_lost=0, filt=0, synchroniser flops=0, debounce counts=0, timer=0.
REQ-022 Reset deassertion SHALL be synchronised internally; first state update occurs no earlier than the second rising edge after deassertion.
REQ-023 Reset asserted mid-search SHALL abandon the search with no residual direction memory.

Structure
REQ-024 State encodings and state width SHALL live in shared package line_tracker_pkg, reused by motor-control blocks.
REQ-025 Per-channel synchroniser+debounce SHALL be one sub-module, sensor_debounce, instantiated N_SENSORS times via generate.
REQ-026 Weight sum SHALL be a combinational loop over channels; only state, line_lost, timer and filt are registered in the top.

Verification
REQ-027 N=3, FILTER_LEN=4: reset, enable=1, sensor=010 held → state=FORWARD exactly 7 edges after sensor change; 1-cycle glitch to 000 → no state change.
REQ-028 N=3: step through all 8 patterns, each held 10 cycles → state matches REQ-020 table, 000 after 110 → STRONG_LEFT.
REQ-029 N=5, STRONG_THRESH=2: 01100 → LEFT (s=-1); 11100 → STRONG_LEFT (s=-3); 00110 → RIGHT; 10001 → BACK.
REQ-030 LOST_TIMEOUT=100: from RIGHT, sensor=000 → STRONG_RIGHT for 100 cycles, then STOP with line_lost=1; sensor=010 → FORWARD, line_lost=0 one edge after filt updates.
REQ-031 Async reset pulse (no clock edge) during search → state=STOP, line_lost=0 immediately; enable=0 while tracking → STOP next edge, timer=0.
